uart_tx_arb: RTL and testbench

Round-robin transmit arbiter that shares the single UART transmitter among three byte sources: the boot banner streamer, the receive-echo path, and a future status reporter. It owns the UART `tx_en`/`tx_data` handshake so that no requester drives the UART directly. An optional line lock keeps one requester's line of text contiguous, and a watchdog recovers if the UART never takes a byte.

---
 rtl/uart_tx_arb_if.sv | 24 ++
 rtl/uart_tx_arb.sv | 134 +++++++++++++
 tb/tb_uart_tx_arb.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Signal bundle between the transmit arbiter, its three byte requesters
// and the shared UART transmitter.
interface uart_tx_arb_if;
  logic [2:0]  req;       // per-requester byte pending
  logic [23:0] req_data;  // byte k on bits [8k+7:8k]
  logic [2:0]  ack;       // one-hot: UART took requester k's byte
  logic [2:0]  gnt;       // one-hot current owner, zero when none
  logic        tx_rdy;    // UART idle and able to accept a byte
  logic        tx_en;     // transmit request to the UART
  logic [7:0]  tx_data;   // byte presented to the UART
  logic        err;       // a send was aborted by the watchdog

  // Arbiter side of the bundle
  modport slave (
    input  req, req_data, tx_rdy,
    output ack, gnt, tx_en, tx_data, err
  );

  // Environment side: requesters plus the UART itself
  modport master (
    output req, req_data, tx_rdy,
    input  ack, gnt, tx_en, tx_data, err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among three byte
// sources. Owns the tx_en/tx_data handshake, optionally locks the grant
// to one requester until it ends its line, and aborts a send with an err
// pulse when the UART never takes the byte.
module uart_tx_arb #(
  parameter int         LINE_LOCK = 1,
  parameter logic [7:0] EOL_CHAR  = 8'h0A,
  parameter int         TIMEOUT   = 1024
) (
  input  logic         clk_50m,
  input  logic         rst_n,
  uart_tx_arb_if.slave bus
);

  // Counter only has to reach TIMEOUT-1; the SEND exit stops it there.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_q;
  logic [1:0]       last_q;     // index of the most recent winner
  logic [2:0]       gnt_q;
  logic [2:0]       ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_en_q;
  logic [7:0]       tx_data_q;
  logic             err_q;

  logic             owner_req;
  logic [2:0]       elig;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [7:0]       win_byte;

  // Requester indices only take the values 0..2, so the successor wraps
  // from 2 back to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Eligible set and round-robin winner, searching last+1, last+2, last+3.
  always_comb begin
    owner_req = |(gnt_q & bus.req);
    // A locked owner that still has a byte pending shuts everyone else out.
    if ((LINE_LOCK != 0) && owner_req) begin
      elig = gnt_q;
    end else begin
      elig = bus.req;
    end

    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = rr_next(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = rr_next(cand);
    end

    win_byte = bus.req_data[{win_idx, 3'b000} +: 8];
  end

  // Arbitration/handshake FSM; every output is a register written here.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      gnt_q     <= 3'b000;
      ack_q     <= 3'b000;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 3'b000;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // tx_rdy must be high again before the next byte: the UART
          // needs its ready to go low then high between bytes.
          if (bus.tx_rdy && win_vld) begin
            gnt_q     <= 3'b001 << win_idx;
            last_q    <= win_idx;
            tx_data_q <= win_byte;
            tx_en_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= SEND;
          end else if (!owner_req) begin
            // Owner has nothing pending: the line lock is released.
            gnt_q <= 3'b000;
          end
        end

        SEND: begin
          // A tx_rdy fall wins over the watchdog when both land together.
          if (!bus.tx_rdy) begin
            tx_en_q <= 1'b0;
            ack_q   <= gnt_q;
            if ((LINE_LOCK == 0) || (tx_data_q == EOL_CHAR)) begin
              gnt_q <= 3'b000;
            end
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort without ack; gnt is kept so the owner retries its byte.
            tx_en_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: instance 0 without line lock, instance 1 with
// line lock, both with an 8-cycle watchdog. Requester queues feed req,
// a UART model answers tx_en, and a per-instance scoreboard of
// {requester, byte} is popped on every ack.
module tb_uart_tx_arb;

  localparam int TMO  = 8;
  localparam int BUSY = 4;
  localparam logic [7:0] OK_LINE [4] = '{8'h6F, 8'h6B, 8'h0D, 8'h0A};

  typedef struct {
    logic [2:0]  mask;   // requesters loaded
    int          depth;  // bytes per loaded requester
    int          n;      // total expected acks
    logic [11:0] ord;    // expected grant order, 2 bits per ack, first in LSBs
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  uart_tx_arb_if bus [2] ();

  int         mode [2];        // 0 manual tx_rdy, 1 UART model, 2 tx_rdy stuck high
  logic       man_rdy [2];
  int         busy [2];
  logic       prev_en [2];
  logic [7:0] launch_data [2];
  logic [2:0] launch_gnt [2];
  logic [7:0] rq [2][3][$];
  logic [9:0] sb [2][$];

  logic [2:0] gnt_m [2];
  logic [2:0] ack_m [2];
  logic       err_m [2];
  logic       tx_en_m [2];
  logic       tx_rdy_m [2];
  logic [7:0] tx_data_m [2];

  always #10 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int oh(input logic [1:0] i);
    return 1 << i;
  endfunction

  function automatic logic [7:0] mkbyte(input int i, input int k, input int d);
    return 8'(16 * i + 4 * k + d);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int g, input int bound, input string nm);
    int c;
    c = 0;
    while (sb[g].size() != 0 && c < bound) begin
      step();
      c++;
    end
    check(nm, sb[g].size(), 0);
  endtask

  task automatic wait_gnt(input int g, input logic [2:0] val, input int bound,
                          input string nm, output int cyc);
    cyc = 0;
    while (gnt_m[g] !== val && cyc < bound) begin
      step();
      cyc++;
    end
    check(nm, int'(gnt_m[g]), int'(val));
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    uart_tx_arb #(
      .LINE_LOCK(g),
      .EOL_CHAR (8'h0A),
      .TIMEOUT  (TMO)
    ) dut (
      .clk_50m(clk),
      .rst_n  (rst_n),
      .bus    (bus[g])
    );

    assign gnt_m[g]     = bus[g].gnt;
    assign ack_m[g]     = bus[g].ack;
    assign err_m[g]     = bus[g].err;
    assign tx_en_m[g]   = bus[g].tx_en;
    assign tx_rdy_m[g]  = bus[g].tx_rdy;
    assign tx_data_m[g] = bus[g].tx_data;

    always @(negedge clk) begin : model
      logic [9:0] e;
      case (mode[g])
        1: begin
          if (busy[g] > 0) begin
            busy[g]--;
            if (busy[g] == 0) bus[g].tx_rdy = 1'b1;
          end else if (bus[g].tx_en && bus[g].tx_rdy) begin
            bus[g].tx_rdy = 1'b0;
            busy[g] = BUSY;
          end else begin
            bus[g].tx_rdy = 1'b1;
          end
        end
        2: begin
          bus[g].tx_rdy = 1'b1;
          busy[g] = 0;
        end
        default: begin
          bus[g].tx_rdy = man_rdy[g];
          busy[g] = 0;
        end
      endcase

      if (bus[g].tx_en && !prev_en[g]) begin
        launch_data[g] = bus[g].tx_data;
        launch_gnt[g]  = bus[g].gnt;
      end
      prev_en[g] = bus[g].tx_en;

      if (bus[g].ack != 3'b000) begin
        if (sb[g].size() == 0) begin
          check("ack_unexpected", int'(bus[g].ack), 0);
        end else begin
          e = sb[g].pop_front();
          check("ack_onehot", int'(bus[g].ack), oh(e[9:8]));
          check("launch_gnt", int'(launch_gnt[g]), oh(e[9:8]));
          check("tx_data", int'(launch_data[g]), int'(e[7:0]));
        end
        for (int k = 0; k < 3; k++) begin
          if (bus[g].ack[k] && rq[g][k].size() > 0) void'(rq[g][k].pop_front());
        end
      end

      for (int k = 0; k < 3; k++) begin
        bus[g].req[k] = (rq[g][k].size() > 0);
        bus[g].req_data[8*k +: 8] = (rq[g][k].size() > 0) ? rq[g][k][0] : 8'h00;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    vec_t       vt [6];
    int         cnt [3];
    int         cyc;
    int         hi;
    logic [1:0] kk;
    logic [7:0] b;

    vt[0] = '{mask: 3'b111, depth: 2, n: 6, ord: {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}};
    vt[1] = '{mask: 3'b101, depth: 1, n: 2, ord: {8'd0, 2'd2, 2'd0}};
    vt[2] = '{mask: 3'b010, depth: 1, n: 1, ord: {10'd0, 2'd1}};
    vt[3] = '{mask: 3'b101, depth: 1, n: 2, ord: {8'd0, 2'd0, 2'd2}};
    vt[4] = '{mask: 3'b110, depth: 2, n: 4, ord: {4'd0, 2'd2, 2'd1, 2'd2, 2'd1}};
    vt[5] = '{mask: 3'b011, depth: 1, n: 2, ord: {8'd0, 2'd1, 2'd0}};

    for (int g = 0; g < 2; g++) begin
      mode[g]    = 1;
      man_rdy[g] = 1'b1;
      busy[g]    = 0;
      prev_en[g] = 1'b0;
    end

    // Reset state of both instances
    rst_n = 1'b0;
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      check("rst_tx_en", int'(tx_en_m[g]), 0);
      check("rst_tx_data", int'(tx_data_m[g]), 0);
      check("rst_ack", int'(ack_m[g]), 0);
      check("rst_gnt", int'(gnt_m[g]), 0);
      check("rst_err", int'(err_m[g]), 0);
    end
    rst_n = 1'b1;
    step();

    // Round-robin vectors on the unlocked instance
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        cnt[k] = 0;
        if (vt[i].mask[k]) begin
          for (int d = 0; d < vt[i].depth; d++) rq[0][k].push_back(mkbyte(i, k, d));
        end
      end
      for (int j = 0; j < vt[i].n; j++) begin
        kk = vt[i].ord[2*j +: 2];
        sb[0].push_back({kk, mkbyte(i, int'(kk), cnt[kk])});
        cnt[kk]++;
      end
      drain(0, 200, "rr_drain");
    end

    // Locked line "ok\r\n" from requester 1 while requester 0 waits
    for (int j = 0; j < 4; j++) begin
      rq[1][1].push_back(OK_LINE[j]);
      sb[1].push_back({2'd1, OK_LINE[j]});
    end
    wait_gnt(1, 3'b010, 20, "lock_owner", cyc);
    rq[1][0].push_back(8'h58);
    sb[1].push_back({2'd0, 8'h58});
    drain(1, 200, "lock_drain");

    // Owner drops req mid-line under lock
    rq[1][2].push_back(8'h61);
    sb[1].push_back({2'd2, 8'h61});
    wait_gnt(1, 3'b100, 20, "mid_owner", cyc);
    rq[1][1].push_back(8'h5A);
    sb[1].push_back({2'd1, 8'h5A});
    cyc = 0;
    while (ack_m[1] !== 3'b100 && cyc < 20) begin
      step();
      cyc++;
    end
    check("mid_ack", int'(ack_m[1]), 3'b100);
    check("mid_hold", int'(gnt_m[1]), 3'b100);
    wait_gnt(1, 3'b000, 2, "mid_release", cyc);
    cyc = 0;
    while (!tx_rdy_m[1] && cyc < 10) begin
      step();
      cyc++;
    end
    check("mid_rdy", int'(tx_rdy_m[1]), 1);
    wait_gnt(1, 3'b010, 2, "mid_regrant", cyc);
    drain(1, 100, "mid_drain");

    // Watchdog: tx_rdy stuck high, then the byte is retried
    mode[0] = 2;
    rq[0][0].push_back(8'h54);
    sb[0].push_back({2'd0, 8'h54});
    cyc = 0;
    while (!tx_en_m[0] && cyc < 10) begin
      step();
      cyc++;
    end
    check("tmo_launch", int'(tx_en_m[0]), 1);
    hi = 0;
    while (tx_en_m[0] && hi < 20) begin
      hi++;
      step();
    end
    check("tmo_width", hi, TMO);
    check("tmo_err", int'(err_m[0]), 1);
    check("tmo_noack", int'(ack_m[0]), 0);
    mode[0] = 1;
    drain(0, 100, "tmo_retry");

    // tx_rdy falls in the same cycle the watchdog expires: success wins
    mode[0]    = 0;
    man_rdy[0] = 1'b1;
    step();
    rq[0][0].push_back(8'h55);
    sb[0].push_back({2'd0, 8'h55});
    cyc = 0;
    while (!tx_en_m[0] && cyc < 10) begin
      step();
      cyc++;
    end
    check("race_launch", int'(tx_en_m[0]), 1);
    repeat (TMO - 2) step();
    man_rdy[0] = 1'b0;
    step();
    check("race_pre_ack", int'(ack_m[0]), 0);
    step();
    check("race_ack", int'(ack_m[0]), 3'b001);
    check("race_err", int'(err_m[0]), 0);
    check("race_tx_en", int'(tx_en_m[0]), 0);
    step();
    check("race_err_after", int'(err_m[0]), 0);
    man_rdy[0] = 1'b1;
    mode[0]    = 1;
    drain(0, 50, "race_drain");

    // Asynchronous reset in the middle of a send
    mode[0] = 2;
    rq[0][1].push_back(8'h66);
    cyc = 0;
    while (!tx_en_m[0] && cyc < 10) begin
      step();
      cyc++;
    end
    check("arst_launch", int'(tx_en_m[0]), 1);
    check("arst_owner", int'(gnt_m[0]), 3'b010);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tx_en", int'(tx_en_m[0]), 0);
    check("arst_gnt", int'(gnt_m[0]), 0);
    check("arst_ack", int'(ack_m[0]), 0);
    b = 8'h30;
    rq[0][0].push_back(b);
    rq[0][2].push_back(8'h32);
    sb[0].push_back({2'd0, b});
    sb[0].push_back({2'd1, 8'h66});
    sb[0].push_back({2'd2, 8'h32});
    mode[0] = 1;
    step();
    step();
    rst_n = 1'b1;
    drain(0, 200, "arst_order");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
